moving_sum_filter: RTL and testbench
====================================

Name: moving_sum_filter

Overview:
- Boxcar (moving-sum / moving-average) stage that sits directly downstream of the fixed-delay shift register in the sensor filter chain.
- It keeps a running sum of the last 2^WINDOW_BITS samples by adding the current sample and subtracting the sample the delay stage returns, which was delayed by exactly the window length.
- The delay stage's storage ignores RESET and holds stale data after reset. This block therefore masks the delayed operand during a fill phase and flags when the output covers a full window.

Parameters:
- DATA_BITS, 32, width of the signed input samples and of OUT_AVG.
- WINDOW_BITS, 4, log2 of the window length W = 2^WINDOW_BITS; legal range 1..10. The upstream delay stage must be instantiated with DELAY_CYCLES = W and the same CE.
- ROUND, 0, OUT_AVG mode: 0 = floor (arithmetic shift), 1 = round half up.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-high reset; takes priority over CE.
- CE  in  1  clock enable; 1 = accept a sample this edge, 0 = hold all state.
- IN_VALUE  in  DATA_BITS  signed current sample; the same value also feeds the delay stage.
- DELAYED_VALUE  in  DATA_BITS  signed output of the delay stage (the sample from W CE-edges earlier).
- OUT_SUM  out  DATA_BITS+WINDOW_BITS  signed running sum (registered).
- OUT_AVG  out  DATA_BITS  signed OUT_SUM / W, per ROUND.
- OUT_VALID  out  1  1 = OUT_SUM covers W real samples.

Behaviour:
- SUM_BITS = DATA_BITS+WINDOW_BITS. This width cannot overflow for W samples; arithmetic is two's complement, sign-extended to SUM_BITS.
- Reset (RESET=1 at an edge, regardless of CE):
  - sum = 0, fill counter = 0, state = FILL.
  - Outputs: OUT_SUM = 0, OUT_AVG = 0, OUT_VALID = 0.
- CE=0 and RESET=0: sum, counter, state and all outputs hold. Only CE edges count as samples.
- State FILL (counter n = 0..W-1):
  - On each CE edge: sum <= sum + IN_VALUE. DELAYED_VALUE is ignored (treated as 0); it is stale or unreset data.
  - Counter increments on each CE edge.
  - On the CE edge where n == W-1: state <= RUN and OUT_VALID <= 1 on that same edge.
- State RUN:
  - On each CE edge: sum <= sum + IN_VALUE - DELAYED_VALUE.
  - Counter is frozen; OUT_VALID stays 1 until reset.
- Latency:
  - A sample present at CE edge k is reflected in OUT_SUM / OUT_AVG immediately after edge k (1 cycle).
  - The first OUT_VALID=1 appears after the W-th CE edge following reset.
- OUT_AVG is combinational from the sum register, so it has the same timing as OUT_SUM:
  - ROUND=0: sum >>> WINDOW_BITS.
  - ROUND=1: (sum + 2^(WINDOW_BITS-1)) >>> WINDOW_BITS, computed at SUM_BITS+1 and truncated to DATA_BITS. The result always fits in DATA_BITS.
- Reset mid-operation: the fill phase restarts fully. Stale delay-line contents must never leak into OUT_SUM; the first W post-reset CE edges use masking.
- Other states: none. An illegal state encoding, if present, must recover to FILL on the next edge.

Test Plan:
Common setup: DATA_BITS=16, WINDOW_BITS=2 (W=4), delay stage DELAY_CYCLES=4 with storage preloaded to 0x7FFF, CE=1 unless stated.
1. Reset, then constant 100 -> OUT_SUM 100, 200, 300, 400, 400...; OUT_VALID rises with the 400 (4th edge); OUT_AVG 100; the preloaded 0x7FFF never appears.
2. Inputs 1,2,3,4,5,6 -> OUT_SUM 1, 3, 6, 10, 14, 18. At sum 10: OUT_AVG = 2 (ROUND=0) / 3 (ROUND=1). At sum 14: OUT_AVG = 3 / 4.
3. Negative rounding: inputs -1,0,0,0 -> sum -1; OUT_AVG = -1 (ROUND=0) / 0 (ROUND=1). Constant -32768 -> sum -131072, OUT_AVG -32768, no wrap. Constant 32767 with ROUND=1 -> OUT_AVG 32767.
4. CE toggling 1,0,1,0... with inputs 10,20,30,40 on the CE=1 edges -> outputs hold on CE=0 edges; OUT_SUM 10, 30, 60, 100; OUT_VALID rises only after the 4th CE=1 edge.
5. In RUN with OUT_SUM=400, assert RESET for one edge, then inputs 5,5,5,5 -> OUT_SUM 0, 5, 10, 15, 20; OUT_VALID 0 until the 20; stale 100s in the delay line are masked.
6. RESET=1 and CE=1 on the same edge with IN_VALUE=77 -> OUT_SUM=0, OUT_VALID=0, counter 0 (reset wins).

Source files
------------

// File: rtl/moving_sum_filter.sv
// Boxcar running-sum stage fed by an external W-deep delay line.
// Masks the unreset delay-line output until W post-reset samples have been accepted.
module moving_sum_filter #(
  parameter int DATA_BITS   = 32,
  parameter int WINDOW_BITS = 4,
  parameter int ROUND       = 0
) (
  input  logic                                    CLK,
  input  logic                                    RESET,
  input  logic                                    CE,
  input  logic signed [DATA_BITS-1:0]             IN_VALUE,
  input  logic signed [DATA_BITS-1:0]             DELAYED_VALUE,
  output logic signed [DATA_BITS+WINDOW_BITS-1:0] OUT_SUM,
  output logic signed [DATA_BITS-1:0]             OUT_AVG,
  output logic                                    OUT_VALID
);

  localparam int SUM_BITS = DATA_BITS + WINDOW_BITS;
  localparam logic [WINDOW_BITS:0] CNT_ZERO = {(WINDOW_BITS+1){1'b0}};
  localparam logic [WINDOW_BITS:0] CNT_ONE  = (WINDOW_BITS+1)'(1);
  localparam logic [WINDOW_BITS:0] CNT_LAST = (WINDOW_BITS+1)'((1 << WINDOW_BITS) - 1);
  localparam logic [SUM_BITS:0]    HALF     = (ROUND != 0) ? (SUM_BITS+1)'(1 << (WINDOW_BITS-1))
                                                           : {(SUM_BITS+1){1'b0}};

  typedef enum logic [1:0] {
    ST_FILL = 2'b01,
    ST_RUN  = 2'b10
  } state_t;

  state_t                     state_r, state_nx;
  logic [WINDOW_BITS:0]       cnt_r, cnt_nx;
  logic signed [SUM_BITS-1:0] sum_r, sum_nx;
  logic                       valid_r, valid_nx;
  logic signed [SUM_BITS-1:0] in_ext_s, dly_ext_s;
  logic signed [SUM_BITS:0]   rnd_s;
  logic                       unused_s;

  assign in_ext_s  = {{WINDOW_BITS{IN_VALUE[DATA_BITS-1]}}, IN_VALUE};
  assign dly_ext_s = {{WINDOW_BITS{DELAYED_VALUE[DATA_BITS-1]}}, DELAYED_VALUE};

  // Next-state, fill counter and running-sum update
  always_comb begin
    state_nx = state_r;
    cnt_nx   = cnt_r;
    sum_nx   = sum_r;
    valid_nx = valid_r;
    case (state_r)
      ST_FILL: begin
        if (CE) begin
          // Delayed operand is stale during fill, so it is left out of the sum.
          sum_nx = sum_r + in_ext_s;
          cnt_nx = cnt_r + CNT_ONE;
          if (cnt_r == CNT_LAST) begin
            state_nx = ST_RUN;
            valid_nx = 1'b1;
          end else begin
            valid_nx = 1'b0;
          end
        end else begin
          state_nx = ST_FILL;
        end
      end
      ST_RUN: begin
        if (CE) begin
          sum_nx = sum_r + in_ext_s - dly_ext_s;
        end else begin
          sum_nx = sum_r;
        end
      end
      default: begin
        // Corrupt encoding: restart the fill exactly as a reset would.
        state_nx = ST_FILL;
        cnt_nx   = CNT_ZERO;
        sum_nx   = {SUM_BITS{1'b0}};
        valid_nx = 1'b0;
      end
    endcase
  end

  // State registers with synchronous reset taking priority over CE
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r <= ST_FILL;
      cnt_r   <= CNT_ZERO;
      sum_r   <= {SUM_BITS{1'b0}};
      valid_r <= 1'b0;
    end else begin
      state_r <= state_nx;
      cnt_r   <= cnt_nx;
      sum_r   <= sum_nx;
      valid_r <= valid_nx;
    end
  end

  // One extra bit keeps the rounding add from overflowing before the shift.
  assign rnd_s    = {sum_r[SUM_BITS-1], sum_r} + $signed(HALF);
  assign unused_s = ^{rnd_s[SUM_BITS], rnd_s[WINDOW_BITS-1:0]};

  assign OUT_SUM   = sum_r;
  assign OUT_AVG   = rnd_s[WINDOW_BITS +: DATA_BITS];
  assign OUT_VALID = valid_r;

endmodule

// File: tb/tb_moving_sum_filter.sv
// Bench for moving_sum_filter (W=4): a floor and a rounding instance share one
// delay line preloaded with 0x7FFF; a window model fills a scoreboard queue.
module tb_moving_sum_filter;

  typedef struct {
    logic signed [17:0] sum;
    logic signed [15:0] avg0;
    logic signed [15:0] avg1;
    logic               valid;
  } exp_t;

  logic               clk_s = 1'b0;
  logic               rst_s = 1'b1;
  logic               ce_s  = 1'b0;
  logic signed [15:0] in_s  = 16'sd0;
  logic signed [15:0] dl_r [4];
  logic signed [17:0] sum0_s, sum1_s;
  logic signed [15:0] avg0_s, avg1_s;
  logic               valid0_s, valid1_s;

  exp_t sb[$];
  int   hist[$];
  int   nacc   = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk_s = ~clk_s;

  moving_sum_filter #(.DATA_BITS(16), .WINDOW_BITS(2), .ROUND(0)) dut_floor (
    .CLK(clk_s), .RESET(rst_s), .CE(ce_s), .IN_VALUE(in_s), .DELAYED_VALUE(dl_r[3]),
    .OUT_SUM(sum0_s), .OUT_AVG(avg0_s), .OUT_VALID(valid0_s));

  moving_sum_filter #(.DATA_BITS(16), .WINDOW_BITS(2), .ROUND(1)) dut_round (
    .CLK(clk_s), .RESET(rst_s), .CE(ce_s), .IN_VALUE(in_s), .DELAYED_VALUE(dl_r[3]),
    .OUT_SUM(sum1_s), .OUT_AVG(avg1_s), .OUT_VALID(valid1_s));

  // Upstream delay stage: W CE-edges deep, not cleared by reset
  initial begin
    for (int i = 0; i < 4; i++) dl_r[i] = 16'sh7FFF;
  end

  always @(posedge clk_s) begin
    if (ce_s) begin
      dl_r[0] <= in_s;
      for (int i = 1; i < 4; i++) dl_r[i] <= dl_r[i-1];
    end
  end

  // Drive one edge and push the window model's expectation for it
  task automatic step(input logic rst, input logic ce, input int val);
    longint s;
    exp_t   e;
    rst_s = rst;
    ce_s  = ce;
    in_s  = 16'(val);
    if (rst) begin
      hist.delete();
      nacc = 0;
    end else if (ce) begin
      hist.push_back(val);
      if (hist.size() > 4) void'(hist.pop_front());
      nacc++;
    end
    s = 0;
    foreach (hist[i]) s += hist[i];
    e.sum   = 18'(s);
    e.avg0  = 16'(s >>> 2);
    e.avg1  = 16'((s + 2) >>> 2);
    e.valid = (nacc >= 4);
    sb.push_back(e);
    @(posedge clk_s);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      step(1'b1, i[0], 1234);
      e = sb.pop_front();
      checks++;
      if ({sum0_s, sum1_s, avg0_s, avg1_s, valid0_s, valid1_s} !== {e.sum, e.sum, e.avg0, e.avg1, e.valid, e.valid}) begin
        errors++;
        $display("FAIL reset[%0d] got sum=%0d/%0d avg=%0d/%0d valid=%b%b want sum=%0d avg=%0d/%0d valid=%b",
                 i, sum0_s, sum1_s, avg0_s, avg1_s, valid0_s, valid1_s, e.sum, e.avg0, e.avg1, e.valid);
      end
    end
  endtask

  task automatic test_constant();
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      step(i == 0, 1'b1, 100);
      e = sb.pop_front();
      checks++;
      if ({sum0_s, sum1_s, avg0_s, avg1_s, valid0_s, valid1_s} !== {e.sum, e.sum, e.avg0, e.avg1, e.valid, e.valid}) begin
        errors++;
        $display("FAIL constant[%0d] got sum=%0d/%0d avg=%0d/%0d valid=%b%b want sum=%0d avg=%0d/%0d valid=%b",
                 i, sum0_s, sum1_s, avg0_s, avg1_s, valid0_s, valid1_s, e.sum, e.avg0, e.avg1, e.valid);
      end
    end
  endtask

  task automatic test_ramp();
    exp_t e;
    for (int i = 0; i < 7; i++) begin
      step(i == 0, 1'b1, i);
      e = sb.pop_front();
      checks++;
      if ({sum0_s, sum1_s, avg0_s, avg1_s, valid0_s, valid1_s} !== {e.sum, e.sum, e.avg0, e.avg1, e.valid, e.valid}) begin
        errors++;
        $display("FAIL ramp[%0d] got sum=%0d/%0d avg=%0d/%0d valid=%b%b want sum=%0d avg=%0d/%0d valid=%b",
                 i, sum0_s, sum1_s, avg0_s, avg1_s, valid0_s, valid1_s, e.sum, e.avg0, e.avg1, e.valid);
      end
    end
  endtask

  task automatic test_negative();
    exp_t e;
    int   rst_tab [17] = '{1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    int   val_tab [17] = '{0, -1, 0, 0, 0,
                           0, -32768, -32768, -32768, -32768, -32768,
                           0, 32767, 32767, 32767, 32767, 32767};
    for (int i = 0; i < 17; i++) begin
      step(rst_tab[i] != 0, 1'b1, val_tab[i]);
      e = sb.pop_front();
      checks++;
      if ({sum0_s, sum1_s, avg0_s, avg1_s, valid0_s, valid1_s} !== {e.sum, e.sum, e.avg0, e.avg1, e.valid, e.valid}) begin
        errors++;
        $display("FAIL negative[%0d] got sum=%0d/%0d avg=%0d/%0d valid=%b%b want sum=%0d avg=%0d/%0d valid=%b",
                 i, sum0_s, sum1_s, avg0_s, avg1_s, valid0_s, valid1_s, e.sum, e.avg0, e.avg1, e.valid);
      end
    end
  endtask

  task automatic test_ce_toggle();
    exp_t e;
    for (int i = 0; i < 13; i++) begin
      if (i == 0) step(1'b1, 1'b1, 0);
      else        step(1'b0, i[0], i[0] ? 10 * ((i + 1) / 2) : 999);
      e = sb.pop_front();
      checks++;
      if ({sum0_s, sum1_s, avg0_s, avg1_s, valid0_s, valid1_s} !== {e.sum, e.sum, e.avg0, e.avg1, e.valid, e.valid}) begin
        errors++;
        $display("FAIL ce_toggle[%0d] got sum=%0d/%0d avg=%0d/%0d valid=%b%b want sum=%0d avg=%0d/%0d valid=%b",
                 i, sum0_s, sum1_s, avg0_s, avg1_s, valid0_s, valid1_s, e.sum, e.avg0, e.avg1, e.valid);
      end
    end
  endtask

  task automatic test_mid_reset();
    exp_t e;
    for (int i = 0; i < 12; i++) begin
      step(i == 0 || i == 6, 1'b1, (i < 6) ? 100 : 5);
      e = sb.pop_front();
      checks++;
      if ({sum0_s, sum1_s, avg0_s, avg1_s, valid0_s, valid1_s} !== {e.sum, e.sum, e.avg0, e.avg1, e.valid, e.valid}) begin
        errors++;
        $display("FAIL mid_reset[%0d] got sum=%0d/%0d avg=%0d/%0d valid=%b%b want sum=%0d avg=%0d/%0d valid=%b",
                 i, sum0_s, sum1_s, avg0_s, avg1_s, valid0_s, valid1_s, e.sum, e.avg0, e.avg1, e.valid);
      end
    end
  endtask

  task automatic test_reset_priority();
    exp_t e;
    for (int i = 0; i < 9; i++) begin
      step(i == 4, 1'b1, (i == 4) ? 77 : 3 * i - 7);
      e = sb.pop_front();
      checks++;
      if ({sum0_s, sum1_s, avg0_s, avg1_s, valid0_s, valid1_s} !== {e.sum, e.sum, e.avg0, e.avg1, e.valid, e.valid}) begin
        errors++;
        $display("FAIL reset_priority[%0d] got sum=%0d/%0d avg=%0d/%0d valid=%b%b want sum=%0d avg=%0d/%0d valid=%b",
                 i, sum0_s, sum1_s, avg0_s, avg1_s, valid0_s, valid1_s, e.sum, e.avg0, e.avg1, e.valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_constant();
    test_ramp();
    test_negative();
    test_ce_toggle();
    test_mid_reset();
    test_reset_priority();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
